fma_line_cache: RTL and testbench

- Parametrised successor to the FMA operand memory.
- Assembles operand lines in a staging register, stores them in an inferred single-port BRAM, and streams lines to the FMA array as "a b c" triples per FMA.
- Adds over the previous generation:
  - a ready/valid instruction handshake;
  - a configurable read latency;
  - a direct-issue WRITE path;
  - correct two's-complement negation in shuffles;
  - an error flag for illegal fields.
- Sits between the instruction controller and the FMA array; takes FMA results back from the FMA write buffer.

---
 rtl/fma_line_cache.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fma_line_cache.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_line_cache.sv
// fma_line_cache: operand line staging, BRAM store and abc line streaming.
// Sits between the instruction controller and the FMA array.
//
// Ports:
//   clk_in, rst_n_in                    clock, async active-low reset
//   instr_in/instr_valid_in/ready_out   instruction handshake
//   controller_reg_b_in                 base value for LOAD
//   write_buffer_in/_valid_in           FMA result line capture
//   abc_out/abc_valid_out               line to the FMAs, one-cycle pulse
//   use_new_c_out, fma_output_can_be_valid_out  FMA mode flags
//   error_out                           pulse on an illegal field
module fma_line_cache #(
  parameter int FMA_COUNT    = 2,
  parameter int WORD_WIDTH   = 16,
  parameter int FIXED_POINT  = 10,
  parameter int DEPTH        = 375,
  parameter int READ_LATENCY = 2,
  localparam int LINE_WIDTH  = 3*FMA_COUNT*WORD_WIDTH,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           instr_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  input  logic [WORD_WIDTH-1:0] controller_reg_b_in,
  input  logic [LINE_WIDTH-1:0] write_buffer_in,
  input  logic                  write_buffer_valid_in,
  output logic [LINE_WIDTH-1:0] abc_out,
  output logic                  abc_valid_out,
  output logic                  use_new_c_out,
  output logic                  fma_output_can_be_valid_out,
  output logic                  error_out
);

  localparam int NW = 3*FMA_COUNT;
  localparam int CW = $clog2(READ_LATENCY+1);

  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_LOAD   = 4'b1101;
  localparam logic [3:0] OP_SENDL  = 4'b1000;
  localparam logic [3:0] OP_LOADB  = 4'b1001;
  localparam logic [3:0] OP_WRITEB = 4'b1010;
  localparam logic [3:0] OP_WRITE  = 4'b1011;

  if (FMA_COUNT < 1 || FMA_COUNT > 5 ||
      READ_LATENCY < 1 ||
      FIXED_POINT >= WORD_WIDTH) begin : g_bad_cfg
    $error("fma_line_cache: bad parameters");
  end

  typedef enum logic [0:0] {
    S_IDLE,
    S_READ
  } state_t;

  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [15:0] imm;

  assign op  = instr_in[31:28];
  assign ra  = instr_in[27:24];
  assign imm = instr_in[23:8];
  assign rb  = instr_in[7:4];
  assign rc  = instr_in[3:0];

  logic                  acc;
  logic                  imm_ok;
  logic [ADDR_WIDTH-1:0] imm_a;
  logic [WORD_WIDTH-1:0] imm_w;

  assign acc    = instr_valid_in & instr_ready_out;
  assign imm_ok = 32'(imm) < DEPTH;
  assign imm_a  = imm[ADDR_WIDTH-1:0];
  assign imm_w  = WORD_WIDTH'(imm);

  logic d_sma;
  logic d_loadi;
  logic d_load;
  logic d_sendl;
  logic d_loadb;
  logic d_writeb;
  logic d_write;
  logic rd_start;

  assign d_sma    = acc && (op == OP_SMA);
  assign d_loadi  = acc && (op == OP_LOADI);
  assign d_load   = acc && (op == OP_LOAD);
  assign d_sendl  = acc && (op == OP_SENDL);
  assign d_loadb  = acc && (op == OP_LOADB);
  assign d_writeb = acc && (op == OP_WRITEB);
  assign d_write  = acc && (op == OP_WRITE);
  assign rd_start = d_writeb && imm_ok;

  logic [WORD_WIDTH-1:0] stg_q [NW];
  logic [LINE_WIDTH-1:0] stg_line;
  logic [LINE_WIDTH-1:0] wb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] abc_q;
  logic [LINE_WIDTH-1:0] rd_q;
  logic                  wr_v_q;
  logic                  rdy_q;
  logic                  err_d;

  state_t       state_q;
  state_t       state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rd_done;

  // word 0 sits in the top bits of the line
  always_comb begin
    stg_line = '0;
    for (int k = 0; k < NW; k++) begin
      stg_line[LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = stg_q[k];
    end
  end

  function automatic logic [WORD_WIDTH-1:0] grp(
    input logic [LINE_WIDTH-1:0] wb,
    input logic [1:0]            g,
    input int                    f
  );
    grp = wb[(int'(g)*FMA_COUNT+f)*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  logic [WORD_WIDTH-1:0] ldb_w [NW];
  logic [NW-1:0]         ldb_ok;
  logic [3:0]            code;
  logic                  ldb_bad;

  // shuffle source per slot; codes 13..15 are negated groups
  always_comb begin
    code   = '0;
    ldb_ok = '1;
    for (int k = 0; k < NW; k++) begin
      code = (k % 3 == 0) ? ra :
             (k % 3 == 1) ? rb : rc;
      ldb_w[k] = '0;
      case (code)
        4'd0: ldb_w[k] = '0;
        4'd1, 4'd2, 4'd3:
          ldb_w[k] = grp(wb_q, 2'(code - 4'd1), k/3);
        4'd4, 4'd5, 4'd6:
          ldb_w[k] = grp(wb_q, 2'(code - 4'd4), k/3) << 1;
        4'd13, 4'd14, 4'd15:
          ldb_w[k] = '0 - grp(wb_q, 2'(4'd15 - code), k/3);
        default: ldb_ok[k] = 1'b0;
      endcase
    end
  end

  assign ldb_bad = ~&ldb_ok;

  always_comb begin
    err_d = 1'b0;
    unique case (1'b1)
      d_sma:    err_d = !imm_ok;
      d_loadi:  err_d = int'(ra) >= NW;
      d_load:   err_d = ra > 4'd2;
      d_loadb:  err_d = ldb_bad;
      d_writeb: err_d = !imm_ok;
      default:  err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NW; k++) begin
        stg_q[k] <= '0;
      end
    end else if (d_loadi && int'(ra) < NW) begin
      for (int k = 0; k < NW; k++) begin
        if (k == int'(ra)) stg_q[k] <= imm_w;
      end
    end else if (d_load && ra <= 4'd2) begin
      for (int k = 0; k < NW; k++) begin
        if (k % 3 == int'(ra)) begin
          stg_q[k] <= controller_reg_b_in +
                      WORD_WIDTH'(k/3) * imm_w;
        end
      end
    end else if (d_loadb) begin
      for (int k = 0; k < NW; k++) begin
        if (ldb_ok[k]) stg_q[k] <= ldb_w[k];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q        <= '0;
      wb_q          <= '0;
      abc_q         <= '0;
      wr_v_q        <= 1'b0;
      error_out     <= 1'b0;
      use_new_c_out <= 1'b0;
      fma_output_can_be_valid_out <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      wr_v_q    <= d_write;
      error_out <= err_d;
      if (write_buffer_valid_in) wb_q <= write_buffer_in;
      if ((d_sma && imm_ok) || rd_start) addr_q <= imm_a;
      if (d_write || rd_start) begin
        use_new_c_out <= (ra == 4'd1);
        fma_output_can_be_valid_out <= (rb == 4'd1);
      end
      if (d_write) begin
        abc_q <= stg_line;
      end else if (rd_done) begin
        abc_q <= rd_q;
      end
    end
  end

  // single-port BRAM: SENDL and WRITEB never share a cycle
  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] port_addr;

  assign port_addr = d_writeb ? imm_a : addr_q;

  always_ff @(posedge clk_in) begin
    if (d_sendl) mem[port_addr] <= stg_line;
    if (rd_start) rd_q <= mem[port_addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          state_d = S_READ;
          cnt_d   = CW'(READ_LATENCY);
        end
      end
      S_READ: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // read data is shown directly on the last READ cycle, then held
  always_comb begin
    rd_done         = (state_q == S_READ) && (cnt_q == CW'(1));
    instr_ready_out = rdy_q && (state_q == S_IDLE);
    abc_valid_out   = wr_v_q | rd_done;
    abc_out         = rd_done ? rd_q : abc_q;
  end

endmodule

// File: tb/tb_fma_line_cache.sv
// tb_fma_line_cache: vector table, directed corner sequences and
// randomized traffic against a behavioural model of fma_line_cache.
module tb_fma_line_cache;

  localparam int F  = 2;
  localparam int W  = 16;
  localparam int D  = 375;
  localparam int RL = 2;
  localparam int NW = 3*F;
  localparam int LW = NW*W;

  typedef logic [LW-1:0] line_t;

  typedef struct {
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       err;
    line_t      exp;
  } ldb_vec_t;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic [31:0]   instr_in = '0;
  logic          instr_valid_in = 1'b0;
  logic          instr_ready_out;
  logic [W-1:0]  controller_reg_b_in = '0;
  line_t         write_buffer_in = '0;
  logic          write_buffer_valid_in = 1'b0;
  line_t         abc_out;
  logic          abc_valid_out;
  logic          use_new_c_out;
  logic          fma_output_can_be_valid_out;
  logic          error_out;

  fma_line_cache #(
    .FMA_COUNT(F), .WORD_WIDTH(W), .FIXED_POINT(10),
    .DEPTH(D), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .instr_in(instr_in),
    .instr_valid_in(instr_valid_in),
    .instr_ready_out(instr_ready_out),
    .controller_reg_b_in(controller_reg_b_in),
    .write_buffer_in(write_buffer_in),
    .write_buffer_valid_in(write_buffer_valid_in),
    .abc_out(abc_out),
    .abc_valid_out(abc_valid_out),
    .use_new_c_out(use_new_c_out),
    .fma_output_can_be_valid_out(fma_output_can_be_valid_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_stg [NW];
  line_t        m_wb;
  int           m_addr;
  line_t        m_mem [D];
  bit           m_wr [D];
  int           wlist [$];
  bit           m_usec;
  bit           m_fcan;
  line_t        m_abc;

  bit    e_exp;
  int    kind_exp;
  line_t line_exp;

  task automatic chk(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [3:0] op, input logic [3:0] ra,
    input logic [15:0] imm, input logic [3:0] rb,
    input logic [3:0] rc);
    return {op, ra, imm, rb, rc};
  endfunction

  function automatic line_t pack();
    line_t l = '0;
    for (int k = 0; k < NW; k++) l[LW-1-k*W -: W] = m_stg[k];
    return l;
  endfunction

  function automatic logic [W-1:0] grp(input int g, input int f);
    return m_wb[(g*F+f)*W +: W];
  endfunction

  function automatic logic [W-1:0] shuf(
    input int c, input int f, output bit ok);
    ok = 1;
    if (c == 0) return '0;
    if (c >= 1 && c <= 3) return grp(c-1, f);
    if (c >= 4 && c <= 6) return grp(c-4, f) << 1;
    if (c >= 13) return 16'(0) - grp(15-c, f);
    ok = 0;
    return '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_stg[k] = '0;
    m_wb = '0;
    m_addr = 0;
    m_usec = 0;
    m_fcan = 0;
    m_abc = '0;
  endtask

  task automatic model_apply(
    input logic [31:0] ins, input logic [W-1:0] rbv,
    input bit wbv, input line_t wbd);
    int op, ra, imm, rb, rc;
    int codes [3];
    bit ok;
    logic [W-1:0] v;
    op = int'(ins[31:28]);
    ra = int'(ins[27:24]);
    imm = int'(ins[23:8]);
    rb = int'(ins[7:4]);
    rc = int'(ins[3:0]);
    e_exp = 0;
    kind_exp = 0;
    case (op)
      6: if (imm >= D) e_exp = 1; else m_addr = imm;
      7: if (ra >= NW) e_exp = 1; else m_stg[ra] = ins[23:8];
      13: begin
        if (ra > 2) e_exp = 1;
        else for (int f = 0; f < F; f++)
          m_stg[f*3+ra] = W'(int'(rbv) + f*imm);
      end
      8: begin
        m_mem[m_addr] = pack();
        if (!m_wr[m_addr]) wlist.push_back(m_addr);
        m_wr[m_addr] = 1;
      end
      9: begin
        codes[0] = ra;
        codes[1] = rb;
        codes[2] = rc;
        for (int s = 0; s < 3; s++) begin
          for (int f = 0; f < F; f++) begin
            v = shuf(codes[s], f, ok);
            if (ok) m_stg[f*3+s] = v;
            else e_exp = 1;
          end
        end
      end
      10: begin
        if (imm >= D) e_exp = 1;
        else begin
          m_addr = imm;
          m_usec = (ra == 1);
          m_fcan = (rb == 1);
          m_abc = m_mem[imm];
          kind_exp = 2;
        end
      end
      11: begin
        m_abc = pack();
        m_usec = (ra == 1);
        m_fcan = (rb == 1);
        kind_exp = 1;
      end
      default: ;
    endcase
    if (wbv) m_wb = wbd;
    line_exp = m_abc;
  endtask

  task automatic check_read(input line_t exp);
    for (int i = 1; i <= RL; i++) begin
      if (i > 1) begin
        @(posedge clk_in);
        #1;
      end
      chkb("rd_ready_low", instr_ready_out, 1'b0);
      chkb("rd_valid", abc_valid_out, i == RL);
    end
    chk("rd_line", abc_out, exp);
    @(posedge clk_in);
    #1;
    chkb("rd_ready_back", instr_ready_out, 1'b1);
    chkb("rd_valid_end", abc_valid_out, 1'b0);
  endtask

  task automatic issue(
    input logic [31:0] ins, input logic [W-1:0] rbv,
    input bit wbv, input line_t wbd, input bit no_wait);
    int n = 0;
    @(negedge clk_in);
    while (!instr_ready_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    instr_in = ins;
    controller_reg_b_in = rbv;
    instr_valid_in = 1'b1;
    write_buffer_valid_in = wbv;
    write_buffer_in = wbd;
    model_apply(ins, rbv, wbv, wbd);
    @(posedge clk_in);
    #1;
    instr_valid_in = 1'b0;
    write_buffer_valid_in = 1'b0;
    chkb("err", error_out, e_exp);
    if (kind_exp == 1) begin
      chkb("wr_valid", abc_valid_out, 1'b1);
      chk("wr_line", abc_out, line_exp);
    end else if (kind_exp == 2) begin
      if (!no_wait) check_read(line_exp);
    end else begin
      chkb("no_valid", abc_valid_out, 1'b0);
    end
    if (kind_exp != 0 && !no_wait) begin
      chkb("use_c", use_new_c_out, m_usec);
      chkb("fcan", fma_output_can_be_valid_out, m_fcan);
    end
  endtask

  task automatic op0(input logic [31:0] ins);
    issue(ins, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_abc"}, abc_out, '0);
    chkb({nm, "_valid"}, abc_valid_out, 1'b0);
    chkb({nm, "_ready"}, instr_ready_out, 1'b0);
    chkb({nm, "_usec"}, use_new_c_out, 1'b0);
    chkb({nm, "_fcan"}, fma_output_can_be_valid_out, 1'b0);
    chkb({nm, "_err"}, error_out, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  localparam line_t WB1 = 96'h0600_0500_0400_0300_0200_0100;
  localparam line_t WB2 = 96'h0000_0000_0000_0000_8888_7777;

  ldb_vec_t vt [5];
  line_t    a;

  initial begin
    vt[0] = '{4'd1, 4'd5, 4'd15, 1'b0,
              96'h0100_0600_FF00_0200_0800_FE00};
    vt[1] = '{4'd0, 4'd2, 4'd3, 1'b0,
              96'h0000_0300_0500_0000_0400_0600};
    vt[2] = '{4'd4, 4'd6, 4'd14, 1'b0,
              96'h0200_0A00_FD00_0400_0C00_FC00};
    vt[3] = '{4'd13, 4'd7, 4'd1, 1'b1,
              96'hFB00_A001_0100_FA00_A004_0200};
    vt[4] = '{4'd12, 4'd0, 4'd8, 1'b1,
              96'hA000_0000_A002_A003_0000_A005};

    for (int i = 0; i < D; i++) m_wr[i] = 0;
    model_reset();

    #2 rst_n_in = 1'b0;
    #1;
    chk_outs_zero("rst");
    repeat (2) @(posedge clk_in);
    #1;
    chk_outs_zero("rst_hold");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chkb("ready_after_rst", instr_ready_out, 1'b1);

    // LOADI, SENDL, WRITEB with read latency
    for (int k = 0; k < NW; k++)
      op0(mk(4'b0111, 4'(k), 16'h0400 + 16'(k), 4'd0, 4'd0));
    op0(mk(4'b0110, 4'd0, 16'd3, 4'd0, 4'd0));
    op0(mk(4'b1000, 4'd0, 16'd0, 4'd0, 4'd0));
    op0(mk(4'b1010, 4'd0, 16'd3, 4'd0, 4'd0));
    chk("t1_line", abc_out, 96'h0400_0401_0402_0403_0404_0405);

    // shuffle with negation
    issue(mk(4'b0000, 4'd0, 16'd0, 4'd0, 4'd0), '0, 1'b1, WB1, 1'b0);
    op0(mk(4'b1001, 4'd1, 16'd0, 4'd5, 4'd15));
    op0(mk(4'b1011, 4'd1, 16'd0, 4'd1, 4'd0));
    chk("t2_line", abc_out, 96'h0100_0600_FF00_0200_0800_FE00);
    chkb("t2_usec", use_new_c_out, 1'b1);

    // shuffle table
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NW; k++)
        op0(mk(4'b0111, 4'(k), 16'hA000 + 16'(k), 4'd0, 4'd0));
      op0(mk(4'b1001, vt[i].ra, 16'd0, vt[i].rb, vt[i].rc));
      chkb("tbl_err", error_out, vt[i].err);
      op0(mk(4'b1011, 4'd0, 16'd0, 4'd0, 4'd0));
      chk("tbl_line", abc_out, vt[i].exp);
    end

    // LOAD wraps modulo 2^16
    issue(mk(4'b1101, 4'd2, 16'd2, 4'd0, 4'd0), 16'hFFFF, 1'b0, '0, 1'b0);
    op0(mk(4'b1011, 4'd0, 16'd0, 4'd0, 4'd0));
    a = abc_out;
    chk("t3_c0", line_t'(a[63:48]), line_t'(16'hFFFF));
    chk("t3_c1", line_t'(a[15:0]), line_t'(16'h0001));

    // illegal fields
    op0(mk(4'b0111, 4'd2, 16'h1234, 4'd0, 4'd0));
    op0(mk(4'b0110, 4'd0, 16'd7, 4'd0, 4'd0));
    op0(mk(4'b1001, 4'd0, 16'd0, 4'd0, 4'd8));
    chkb("t4_err_ldb", error_out, 1'b1);
    op0(mk(4'b0110, 4'd0, 16'd400, 4'd0, 4'd0));
    chkb("t4_err_sma", error_out, 1'b1);
    op0(mk(4'b0111, 4'd6, 16'h5555, 4'd0, 4'd0));
    chkb("t4_err_ldi", error_out, 1'b1);
    op0(mk(4'b1011, 4'd0, 16'd0, 4'd0, 4'd0));
    a = abc_out;
    chk("t4_c_kept", line_t'(a[63:48]), line_t'(16'h1234));
    chk("t4_a_zero", line_t'(a[95:80]), line_t'(16'h0000));
    op0(mk(4'b0111, 4'd0, 16'hBEEF, 4'd0, 4'd0));
    op0(mk(4'b1000, 4'd0, 16'd0, 4'd0, 4'd0));
    op0(mk(4'b1010, 4'd0, 16'd7, 4'd0, 4'd0));
    a = abc_out;
    chk("t4_addr_kept", line_t'(a[95:80]), line_t'(16'hBEEF));

    // same-cycle latch update
    issue(mk(4'b0000, 4'd0, 16'd0, 4'd0, 4'd0), '0, 1'b1, WB1, 1'b0);
    issue(mk(4'b1001, 4'd1, 16'd0, 4'd0, 4'd0), '0, 1'b1, WB2, 1'b0);
    op0(mk(4'b1011, 4'd0, 16'd0, 4'd0, 4'd0));
    a = abc_out;
    chk("t5_old", line_t'({a[95:80], a[47:32]}), line_t'(32'h0100_0200));
    op0(mk(4'b1001, 4'd1, 16'd0, 4'd0, 4'd0));
    op0(mk(4'b1011, 4'd0, 16'd0, 4'd0, 4'd0));
    a = abc_out;
    chk("t5_new", line_t'({a[95:80], a[47:32]}), line_t'(32'h7777_8888));

    // reset during a read
    issue(mk(4'b1010, 4'd1, 16'd3, 4'd1, 4'd0), '0, 1'b0, '0, 1'b1);
    rst_n_in = 1'b0;
    #1;
    model_reset();
    chk_outs_zero("t6_rst");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chkb("t6_ready", instr_ready_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chkb("t6_no_valid", abc_valid_out, 1'b0);
      @(posedge clk_in);
      #1;
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op, ra, rb, rc;
      logic [15:0] imm;
      logic [W-1:0] rbv;
      bit wbv;
      line_t wbd;
      int sel;
      sel = $urandom_range(0, 8);
      ra = 4'($urandom_range(0, 2));
      rb = 4'($urandom_range(0, 2));
      rc = 4'($urandom_range(0, 15));
      imm = 16'($urandom);
      rbv = W'($urandom);
      wbv = ($urandom_range(0, 3) == 0);
      wbd = {$urandom, $urandom, $urandom};
      case (sel)
        0: begin op = 4'b0110; imm = 16'($urandom_range(0, 420)); end
        1: begin op = 4'b0111; ra = 4'($urandom_range(0, 7)); end
        2: begin op = 4'b1101; ra = 4'($urandom_range(0, 3)); end
        3: op = 4'b1000;
        4: begin
          op = 4'b1001;
          ra = 4'($urandom_range(0, 15));
          rb = 4'($urandom_range(0, 15));
        end
        5, 6: begin
          op = 4'b1010;
          if (wlist.size() == 0 || $urandom_range(0, 5) == 0)
            imm = 16'($urandom_range(D, 1000));
          else
            imm = 16'(wlist[$urandom_range(0, wlist.size()-1)]);
        end
        7: op = 4'b1011;
        default: op = 4'($urandom_range(0, 5));
      endcase
      issue(mk(op, ra, imm, rb, rc), rbv, wbv, wbd, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
